// File: rtl/ring_decoder_4_bit.sv
// ----------------------------------------------------------------------------
// ring_decoder_4_bit
// Receive-side decoder/monitor for a 4-bit one-hot ring counter bus.
// Converts the one-hot position into a binary index, acquires lock after
// LOCK_CNT consecutive correctly rotating samples, pulses err on sequence
// errors while locked, and keeps a saturating error count plus a modulo
// wrap count (3->0 transitions accepted while locked).
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   en         in   sample enable (low: all state holds, err=0)
//   ring_in    in   4-bit ring code, bit i high means position i
//   clr_cnt    in   synchronous clear of err_count/wrap_count (ignores en)
//   pos        out  binary index of the last legal sample
//   locked     out  high while in LOCKED
//   err        out  one-cycle pulse on a sequence error while LOCKED
//   err_count  out  saturating count of err pulses
//   wrap_count out  modulo-2^CNT_W count of 3->0 wraps seen while LOCKED
// ----------------------------------------------------------------------------
module ring_decoder_4_bit #(
  parameter int LOCK_CNT = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       ring_in,
  input  logic             clr_cnt,
  output logic [1:0]       pos,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count
);

  typedef enum logic [0:0] {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_e;

  localparam logic [3:0]       LOCK_CNT_L = 4'(LOCK_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  // Exactly one bit set.
  function automatic logic is_onehot(input logic [3:0] code);
    logic [2:0] ones;
    ones = 3'd0;
    for (int i = 0; i < 4; i++) begin
      ones = ones + {2'b00, code[i]};
    end
    return (ones == 3'd1);
  endfunction

  // Binary index of a one-hot code (only meaningful for legal codes).
  function automatic logic [1:0] onehot_index(input logic [3:0] code);
    logic [1:0] idx;
    case (code)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  state_e           state_q, state_d;
  logic [3:0]       prev_q, prev_d;
  logic             prev_ok_q, prev_ok_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic [1:0]       pos_q, pos_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] wrap_count_q, wrap_count_d;

  logic       legal_s;
  logic       zero_s;
  logic       succ_s;
  logic [1:0] idx_s;
  logic [3:0] match_inc_s;
  logic       inc_err_s;
  logic       inc_wrap_s;

  assign legal_s     = is_onehot(ring_in);
  assign zero_s      = (ring_in == 4'b0000);
  assign idx_s       = onehot_index(ring_in);
  // Successor is a left rotation of the last legal sample.
  assign succ_s      = prev_ok_q && (ring_in == {prev_q[2:0], prev_q[3]});
  assign match_inc_s = succ_s ? (match_cnt_q + 4'd1) : 4'd1;

  // Next-state logic for the lock FSM, tracking state and outputs.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    prev_ok_d   = prev_ok_q;
    match_cnt_d = match_cnt_q;
    pos_d       = pos_q;
    err_d       = 1'b0;
    inc_err_s   = 1'b0;
    inc_wrap_s  = 1'b0;
    if (en) begin
      case (state_q)
        ST_UNLOCKED: begin
          if (legal_s) begin
            match_cnt_d = match_inc_s;
            prev_d      = ring_in;
            prev_ok_d   = 1'b1;
            pos_d       = idx_s;
            if (match_inc_s == LOCK_CNT_L) begin
              state_d = ST_LOCKED;
            end else begin
              state_d = ST_UNLOCKED;
            end
          end else begin
            match_cnt_d = 4'd0;
            prev_ok_d   = 1'b0;
          end
        end
        ST_LOCKED: begin
          if (legal_s && succ_s) begin
            prev_d = ring_in;
            pos_d  = idx_s;
            // Successor of 1000 is 0001: a wrap.
            if (prev_q == 4'b1000) begin
              inc_wrap_s = 1'b1;
            end else begin
              inc_wrap_s = 1'b0;
            end
          end else if (legal_s) begin
            // Skip/hold/reverse: this sample starts re-acquisition.
            err_d       = 1'b1;
            inc_err_s   = 1'b1;
            state_d     = ST_UNLOCKED;
            match_cnt_d = 4'd1;
            prev_d      = ring_in;
            prev_ok_d   = 1'b1;
            pos_d       = idx_s;
          end else if (zero_s) begin
            // Source ring held in reset: drop lock without flagging.
            state_d     = ST_UNLOCKED;
            match_cnt_d = 4'd0;
            prev_ok_d   = 1'b0;
          end else begin
            err_d       = 1'b1;
            inc_err_s   = 1'b1;
            state_d     = ST_UNLOCKED;
            match_cnt_d = 4'd0;
            prev_ok_d   = 1'b0;
          end
        end
        default: begin
          state_d     = ST_UNLOCKED;
          match_cnt_d = 4'd0;
          prev_ok_d   = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Counter next-state: clear has priority over any increment.
  always_comb begin
    err_count_d  = err_count_q;
    wrap_count_d = wrap_count_q;
    if (clr_cnt) begin
      err_count_d  = {CNT_W{1'b0}};
      wrap_count_d = {CNT_W{1'b0}};
    end else begin
      if (inc_err_s && (err_count_q != CNT_MAX)) begin
        err_count_d = err_count_q + CNT_ONE;
      end else begin
        err_count_d = err_count_q;
      end
      if (inc_wrap_s) begin
        wrap_count_d = wrap_count_q + CNT_ONE;
      end else begin
        wrap_count_d = wrap_count_q;
      end
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_UNLOCKED;
      prev_q       <= 4'b0000;
      prev_ok_q    <= 1'b0;
      match_cnt_q  <= 4'd0;
      pos_q        <= 2'd0;
      err_q        <= 1'b0;
      err_count_q  <= {CNT_W{1'b0}};
      wrap_count_q <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      prev_ok_q    <= prev_ok_d;
      match_cnt_q  <= match_cnt_d;
      pos_q        <= pos_d;
      err_q        <= err_d;
      err_count_q  <= err_count_d;
      wrap_count_q <= wrap_count_d;
    end
  end

  assign pos        = pos_q;
  assign locked     = (state_q == ST_LOCKED);
  assign err        = err_q;
  assign err_count  = err_count_q;
  assign wrap_count = wrap_count_q;

endmodule

// File: tb/tb_ring_decoder_4_bit.sv
// ----------------------------------------------------------------------------
// Testbench for ring_decoder_4_bit (LOCK_CNT=3, CNT_W=8). Directed steps from
// the test plan followed by randomized traffic, all compared against a
// behavioural model that works on integer positions and run lengths.
// ----------------------------------------------------------------------------
module tb_ring_decoder_4_bit;

  localparam int LOCK = 3;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] ring_in;
  logic       clr_cnt;
  logic [1:0] pos;
  logic       locked;
  logic       err;
  logic [7:0] err_count;
  logic [7:0] wrap_count;

  int n_chk;
  int n_fail;

  // Behavioural model state.
  int m_pos, m_locked, m_err, m_errs, m_wraps, m_last, m_run;

  ring_decoder_4_bit #(.LOCK_CNT(LOCK), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .ring_in    (ring_in),
    .clr_cnt    (clr_cnt),
    .pos        (pos),
    .locked     (locked),
    .err        (err),
    .err_count  (err_count),
    .wrap_count (wrap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pos"},    {30'd0, pos},        m_pos);
    check({tag, ".locked"}, {31'd0, locked},     m_locked);
    check({tag, ".err"},    {31'd0, err},        m_err);
    check({tag, ".errcnt"}, {24'd0, err_count},  m_errs);
    check({tag, ".wrapcnt"},{24'd0, wrap_count}, m_wraps);
  endtask

  task automatic model_reset();
    m_pos = 0; m_locked = 0; m_err = 0; m_errs = 0; m_wraps = 0;
    m_last = -1; m_run = 0;
  endtask

  task automatic model_step(input logic e, input logic [3:0] r, input logic c);
    int ones, idx, good, inc_e, inc_w;
    ones = 0; idx = 0; inc_e = 0; inc_w = 0;
    m_err = 0;
    if (e) begin
      for (int i = 0; i < 4; i++) if (r[i]) begin ones++; idx = i; end
      if (ones == 1) begin
        good = (m_last >= 0) && (idx == (m_last + 1) % 4);
        if (m_locked != 0) begin
          if (good) begin
            if (m_last == 3) inc_w = 1;
          end else begin
            m_err = 1; inc_e = 1; m_locked = 0; m_run = 1;
          end
        end else begin
          m_run = good ? m_run + 1 : 1;
          if (m_run == LOCK) m_locked = 1;
        end
        m_last = idx;
        m_pos  = idx;
      end else begin
        if (m_locked != 0 && ones > 1) begin m_err = 1; inc_e = 1; end
        m_locked = 0; m_run = 0; m_last = -1;
      end
    end
    if (c) begin
      m_errs = 0; m_wraps = 0;
    end else begin
      if (inc_e != 0 && m_errs < 255) m_errs++;
      if (inc_w != 0) m_wraps = (m_wraps + 1) % 256;
    end
  endtask

  task automatic step(input string tag, input logic e, input logic [3:0] r, input logic c);
    en = e; ring_in = r; clr_cnt = c;
    @(posedge clk);
    #1;
    model_step(e, r, c);
    check_all(tag);
  endtask

  initial begin
    logic [3:0] one;
    logic [3:0] r;
    int s_idx, k;
    logic e, c;
    n_chk = 0; n_fail = 0;
    one = 4'b0001;
    rst = 1'b0; en = 1'b0; ring_in = 4'b0000; clr_cnt = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // Clean acquisition and first wrap.
    step("acq0", 1'b1, 4'b0001, 1'b0);
    step("acq1", 1'b1, 4'b0010, 1'b0);
    step("acq2", 1'b1, 4'b0100, 1'b0);
    check("lock_after_3", {31'd0, locked}, 32'd1);
    step("acq3", 1'b1, 4'b1000, 1'b0);
    step("acq4", 1'b1, 4'b0001, 1'b0);
    check("first_wrap", {24'd0, wrap_count}, 32'd1);

    // Skip error then re-lock in two edges.
    step("pre_skip", 1'b1, 4'b0010, 1'b0);
    step("skip", 1'b1, 4'b1000, 1'b0);
    check("skip_pos", {30'd0, pos}, 32'd3);
    step("relock0", 1'b1, 4'b0001, 1'b0);
    step("relock1", 1'b1, 4'b0010, 1'b0);
    check("relocked", {31'd0, locked}, 32'd1);

    // Illegal code while locked, then lock again and drop with zero code.
    step("illegal", 1'b1, 4'b0110, 1'b0);
    check("illegal_pos_hold", {30'd0, pos}, 32'd1);
    step("l0", 1'b1, 4'b0100, 1'b0);
    step("l1", 1'b1, 4'b1000, 1'b0);
    step("l2", 1'b1, 4'b0001, 1'b0);
    step("zero", 1'b1, 4'b0000, 1'b0);

    // Freeze with en low while locked at 0100.
    step("f0", 1'b1, 4'b0001, 1'b0);
    step("f1", 1'b1, 4'b0010, 1'b0);
    step("f2", 1'b1, 4'b0100, 1'b0);
    step("hold0", 1'b0, 4'b1111, 1'b0);
    step("hold1", 1'b0, 4'b0000, 1'b0);
    step("hold2", 1'b0, 4'b0001, 1'b0);
    step("resume", 1'b1, 4'b1000, 1'b0);
    check("resume_pos", {30'd0, pos}, 32'd3);

    // Saturate err_count with 300 errors.
    for (int n = 0; n < 300; n++) begin
      step("sat_l0", 1'b1, 4'b0001, 1'b0);
      step("sat_l1", 1'b1, 4'b0010, 1'b0);
      step("sat_l2", 1'b1, 4'b0100, 1'b0);
      step("sat_err", 1'b1, 4'b0110, 1'b0);
    end
    check("err_sat", {24'd0, err_count}, 32'd255);
    step("c0", 1'b1, 4'b0001, 1'b0);
    step("c1", 1'b1, 4'b0010, 1'b0);
    step("c2", 1'b1, 4'b0100, 1'b0);
    step("clr_vs_err", 1'b1, 4'b0010, 1'b1);
    check("clr_wins", {24'd0, err_count}, 32'd0);

    // Randomized traffic.
    s_idx = 0;
    for (int n = 0; n < 1500; n++) begin
      e = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 49) == 0);
      k = $urandom_range(0, 19);
      if (k < 14) begin
        s_idx = (s_idx + 1) % 4; r = one << s_idx;
      end else if (k < 16) begin
        r = one << s_idx;
      end else if (k == 16) begin
        s_idx = (s_idx + 2) % 4; r = one << s_idx;
      end else if (k == 17) begin
        s_idx = (s_idx + 3) % 4; r = one << s_idx;
      end else if (k == 18) begin
        r = 4'b0000;
      end else begin
        r = 4'($urandom_range(0, 15));
      end
      step("rand", e, r, c);
    end

    // Asynchronous reset between edges while locked.
    step("ar0", 1'b1, 4'b0001, 1'b0);
    step("ar1", 1'b1, 4'b0010, 1'b0);
    step("ar2", 1'b1, 4'b0100, 1'b0);
    step("ar3", 1'b1, 4'b1000, 1'b0);
    step("ar4", 1'b1, 4'b0001, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    en = 1'b1; ring_in = 4'b0110; clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    check_all("rst_hold");
    @(negedge clk);
    rst = 1'b1;
    step("post_rst", 1'b1, 4'b0001, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
